// File: rtl/dphy_rx_lane_aligner.sv
// Four-lane D-PHY HS word deskew: per-lane FIFOs absorb start skew, then one 64-bit word per cycle.
// Optional build macro DPHY_ALIGN_STATS_EN adds saturating burst/error statistics outputs.
module dphy_rx_lane_aligner #(
    parameter int FIFO_DEPTH = 8,
    parameter int SKEW_MAX   = 4
) (
    input  logic        SLOWCLK,
    input  logic        RST0_N,
    input  logic [3:0]  rx_valid_hs,
    input  logic [15:0] rx_data_hs_lan0,
    input  logic [15:0] rx_data_hs_lan1,
    input  logic [15:0] rx_data_hs_lan2,
    input  logic [15:0] rx_data_hs_lan3,
    output logic        out_valid,
    output logic [63:0] out_data,
    output logic        out_sop,
    output logic        burst_done,
    output logic        residual,
    output logic        align_err,
    output logic        ovf_err
`ifdef DPHY_ALIGN_STATS_EN
    ,
    output logic [15:0] stat_bursts,
    output logic [15:0] stat_align_err,
    output logic [15:0] stat_ovf_err
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(SKEW_MAX + 1);
    localparam logic [CW-1:0] SKEW_LIM  = CW'(SKEW_MAX);
    localparam logic [CW-1:0] IDLE_LAST = CW'(SKEW_MAX - 1);
    localparam logic [AW:0]   CNT_FULL  = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_ALIGN, ST_STREAM, ST_DISCARD} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  skew_cnt_q, skew_cnt_d;
    logic [CW-1:0]  idle_cnt_q, idle_cnt_d;
    logic           sop_pend_q, sop_pend_d;
    logic           out_valid_q, out_sop_q;
    logic [63:0]    out_data_q;
    logic           burst_done_q, burst_done_d;
    logic           residual_q, residual_d;
    logic           align_err_q, align_err_d;
    logic           ovf_err_q, ovf_err_d;

    logic [15:0]    lane_data [4];
    logic [15:0]    head      [4];
    logic [3:0]     wr_en;
    logic [3:0]     full;
    logic [3:0]     nonempty;
    logic [3:0]     ovf_lane;
    logic [3:0]     left;
    logic           all_ne;
    logic           pop;
    logic           flush;

    assign lane_data[0] = rx_data_hs_lan0;
    assign lane_data[1] = rx_data_hs_lan1;
    assign lane_data[2] = rx_data_hs_lan2;
    assign lane_data[3] = rx_data_hs_lan3;

    assign wr_en  = (state_q != ST_DISCARD) ? rx_valid_hs : 4'b0000;
    assign all_ne = &nonempty;
    assign pop    = (state_q == ST_STREAM) && all_ne;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [15:0]   mem [FIFO_DEPTH];
            logic [AW-1:0] wr_ptr_q, rd_ptr_q;
            logic [AW:0]   cnt_q;

            assign full[gi]     = (cnt_q == CNT_FULL);
            assign nonempty[gi] = (cnt_q != '0);
            assign head[gi]     = mem[rd_ptr_q];
            // A pop in the same cycle frees a slot, so a full lane may still accept a write.
            assign ovf_lane[gi] = wr_en[gi] && full[gi] && !pop;
            assign left[gi]     = pop ? (cnt_q > (AW+1)'(1)) : (cnt_q != '0);

            always_ff @(posedge SLOWCLK) begin
                if (wr_en[gi]) begin
                    mem[wr_ptr_q] <= lane_data[gi];
                end
            end

            always_ff @(posedge SLOWCLK or negedge RST0_N) begin
                if (!RST0_N) begin
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                    cnt_q    <= '0;
                end else if (flush) begin
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                    cnt_q    <= '0;
                end else begin
                    if (wr_en[gi]) wr_ptr_q <= wr_ptr_q + AW'(1);
                    if (pop)       rd_ptr_q <= rd_ptr_q + AW'(1);
                    cnt_q <= cnt_q + (AW+1)'(wr_en[gi]) - (AW+1)'(pop);
                end
            end
        end
    endgenerate

    always_comb begin
        state_d      = state_q;
        skew_cnt_d   = skew_cnt_q;
        idle_cnt_d   = idle_cnt_q;
        sop_pend_d   = sop_pend_q;
        flush        = 1'b0;
        burst_done_d = 1'b0;
        residual_d   = 1'b0;
        align_err_d  = 1'b0;
        ovf_err_d    = 1'b0;

        if (pop) sop_pend_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (|rx_valid_hs) begin
                    state_d    = ST_ALIGN;
                    skew_cnt_d = '0;
                    idle_cnt_d = '0;
                    sop_pend_d = 1'b1;
                end
            end
            ST_ALIGN: begin
                if (all_ne) begin
                    state_d    = ST_STREAM;
                    idle_cnt_d = '0;
                end else if (skew_cnt_q == SKEW_LIM) begin
                    align_err_d = 1'b1;
                    flush       = 1'b1;
                    state_d     = ST_DISCARD;
                    idle_cnt_d  = '0;
                end else begin
                    skew_cnt_d = skew_cnt_q + CW'(1);
                end
            end
            ST_STREAM: begin
                if (rx_valid_hs == 4'b0000) begin
                    if (idle_cnt_q == IDLE_LAST) begin
                        burst_done_d = 1'b1;
                        residual_d   = |left;
                        flush        = 1'b1;
                        state_d      = ST_IDLE;
                        idle_cnt_d   = '0;
                    end else begin
                        idle_cnt_d = idle_cnt_q + CW'(1);
                    end
                end else begin
                    idle_cnt_d = '0;
                end
            end
            default: begin
                if (rx_valid_hs == 4'b0000) begin
                    if (idle_cnt_q == IDLE_LAST) begin
                        state_d    = ST_IDLE;
                        idle_cnt_d = '0;
                    end else begin
                        idle_cnt_d = idle_cnt_q + CW'(1);
                    end
                end else begin
                    idle_cnt_d = '0;
                end
            end
        endcase

        // Overflow overrides everything else; the word popped this cycle is still emitted.
        if (|ovf_lane) begin
            ovf_err_d    = 1'b1;
            flush        = 1'b1;
            state_d      = ST_DISCARD;
            idle_cnt_d   = '0;
            align_err_d  = 1'b0;
            burst_done_d = 1'b0;
            residual_d   = 1'b0;
        end
    end

    always_ff @(posedge SLOWCLK or negedge RST0_N) begin
        if (!RST0_N) begin
            state_q      <= ST_IDLE;
            skew_cnt_q   <= '0;
            idle_cnt_q   <= '0;
            sop_pend_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_sop_q    <= 1'b0;
            out_data_q   <= '0;
            burst_done_q <= 1'b0;
            residual_q   <= 1'b0;
            align_err_q  <= 1'b0;
            ovf_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            skew_cnt_q   <= skew_cnt_d;
            idle_cnt_q   <= idle_cnt_d;
            sop_pend_q   <= sop_pend_d;
            out_valid_q  <= pop;
            out_sop_q    <= pop && sop_pend_q;
            if (pop) out_data_q <= {head[3], head[2], head[1], head[0]};
            burst_done_q <= burst_done_d;
            residual_q   <= residual_d;
            align_err_q  <= align_err_d;
            ovf_err_q    <= ovf_err_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_sop    = out_sop_q;
    assign burst_done = burst_done_q;
    assign residual   = residual_q;
    assign align_err  = align_err_q;
    assign ovf_err    = ovf_err_q;

`ifdef DPHY_ALIGN_STATS_EN
    logic [15:0] stat_bursts_q, stat_align_q, stat_ovf_q;

    always_ff @(posedge SLOWCLK or negedge RST0_N) begin
        if (!RST0_N) begin
            stat_bursts_q <= '0;
            stat_align_q  <= '0;
            stat_ovf_q    <= '0;
        end else begin
            if (burst_done_d && stat_bursts_q != 16'hFFFF) stat_bursts_q <= stat_bursts_q + 16'd1;
            if (align_err_d  && stat_align_q  != 16'hFFFF) stat_align_q  <= stat_align_q  + 16'd1;
            if (ovf_err_d    && stat_ovf_q    != 16'hFFFF) stat_ovf_q    <= stat_ovf_q    + 16'd1;
        end
    end

    assign stat_bursts    = stat_bursts_q;
    assign stat_align_err = stat_align_q;
    assign stat_ovf_err   = stat_ovf_q;
`endif

endmodule

// File: tb/tb_dphy_rx_lane_aligner.sv
// Bench for dphy_rx_lane_aligner: table of per-lane valid masks with expected outcomes,
// a word scoreboard, plus hand-written reset sequences.
module tb_dphy_rx_lane_aligner;

    logic        SLOWCLK;
    logic        RST0_N;
    logic [3:0]  rx_valid_hs;
    logic [15:0] rx_data_hs_lan0, rx_data_hs_lan1, rx_data_hs_lan2, rx_data_hs_lan3;
    logic        out_valid;
    logic [63:0] out_data;
    logic        out_sop, burst_done, residual, align_err, ovf_err;
`ifdef DPHY_ALIGN_STATS_EN
    logic [15:0] stat_bursts, stat_align_err, stat_ovf_err;
`endif

    dphy_rx_lane_aligner #(.FIFO_DEPTH(8), .SKEW_MAX(4)) dut (
        .SLOWCLK        (SLOWCLK),
        .RST0_N         (RST0_N),
        .rx_valid_hs    (rx_valid_hs),
        .rx_data_hs_lan0(rx_data_hs_lan0),
        .rx_data_hs_lan1(rx_data_hs_lan1),
        .rx_data_hs_lan2(rx_data_hs_lan2),
        .rx_data_hs_lan3(rx_data_hs_lan3),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_sop        (out_sop),
        .burst_done     (burst_done),
        .residual       (residual),
        .align_err      (align_err),
        .ovf_err        (ovf_err)
`ifdef DPHY_ALIGN_STATS_EN
        ,
        .stat_bursts    (stat_bursts),
        .stat_align_err (stat_align_err),
        .stat_ovf_err   (stat_ovf_err)
`endif
    );

    initial SLOWCLK = 1'b0;
    always #5 SLOWCLK = ~SLOWCLK;

    int cyc = 0;
    always @(posedge SLOWCLK) cyc <= cyc + 1;

    typedef struct {
        string       name;
        logic [31:0] m0, m1, m2, m3;
        int          words, done, res, aerr, oerr, lat;
    } scn_t;

    typedef struct {
        logic [63:0] d;
        logic        sop;
    } exp_t;

    scn_t        tbl [10];
    exp_t        sb [$];
    int          checks = 0;
    int          passes = 0;
    int          n_words = 0, n_done = 0, n_res = 0, n_res_alone = 0, n_aerr = 0, n_oerr = 0;
    int          sop_cyc = -1;
    int          k_lane [4];
    logic [15:0] base;
    logic [63:0] last_data = '0;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0h required %0h", name, act, req);
    endtask

    task automatic sample();
        exp_t e;
        if (out_valid) begin
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL unexpected_word: got %h required no word", out_data);
            end else begin
                e = sb.pop_front();
                chk("word_data", 72'(out_data), 72'(e.d));
                chk("word_sop", 72'(out_sop), 72'(e.sop));
                last_data = e.d;
            end
            n_words++;
            if (out_sop) sop_cyc = cyc;
        end else begin
            chk("idle_hold", 72'({out_sop, out_data}), 72'({1'b0, last_data}));
        end
        if (burst_done) n_done++;
        if (residual) n_res++;
        if (residual && !burst_done) n_res_alone++;
        if (align_err) n_aerr++;
        if (ovf_err) n_oerr++;
    endtask

    // One cycle: look at the outputs on the falling edge, then present this cycle's lane inputs.
    task automatic step(input logic [3:0] v);
        logic [15:0] d [4];
        @(negedge SLOWCLK);
        sample();
        for (int n = 0; n < 4; n++) begin
            if (v[n]) begin
                d[n] = 16'(n * 16'h1000) + base + 16'(k_lane[n]);
                k_lane[n]++;
            end else begin
                d[n] = 16'($urandom);
            end
        end
        rx_valid_hs     = v;
        rx_data_hs_lan0 = d[0];
        rx_data_hs_lan1 = d[1];
        rx_data_hs_lan2 = d[2];
        rx_data_hs_lan3 = d[3];
    endtask

    task automatic push_words(input int cnt);
        exp_t e;
        for (int i = 0; i < cnt; i++) begin
            e.d   = {16'h3000 + base + 16'(i), 16'h2000 + base + 16'(i),
                     16'h1000 + base + 16'(i), base + 16'(i)};
            e.sop = (i == 0);
            sb.push_back(e);
        end
        for (int n = 0; n < 4; n++) k_lane[n] = 0;
    endtask

    task automatic run_scn(input scn_t t, input logic [15:0] b);
        int s, w0, d0, r0, ra0, a0, o0;
        base = b;
        push_words(t.words);
        w0 = n_words; d0 = n_done; r0 = n_res; ra0 = n_res_alone; a0 = n_aerr; o0 = n_oerr;
        sop_cyc = -1;
        s = 0;
        for (int c = 0; c < 40; c++) begin
            if (c == 0) begin
                @(negedge SLOWCLK);
                sample();
                s = cyc;
                base = b;
                rx_valid_hs     = {t.m3[0], t.m2[0], t.m1[0], t.m0[0]};
                rx_data_hs_lan0 = t.m0[0] ? base : 16'($urandom);
                rx_data_hs_lan1 = t.m1[0] ? 16'h1000 + base : 16'($urandom);
                rx_data_hs_lan2 = t.m2[0] ? 16'h2000 + base : 16'($urandom);
                rx_data_hs_lan3 = t.m3[0] ? 16'h3000 + base : 16'($urandom);
                for (int n = 0; n < 4; n++) k_lane[n] = rx_valid_hs[n] ? 1 : 0;
            end else if (c < 32) begin
                step({t.m3[c], t.m2[c], t.m1[c], t.m0[c]});
            end else begin
                step(4'b0000);
            end
        end
        chk({t.name, "_words"}, 72'(n_words - w0), 72'(t.words));
        chk({t.name, "_burst_done"}, 72'(n_done - d0), 72'(t.done));
        chk({t.name, "_residual"}, 72'(n_res - r0), 72'(t.res));
        chk({t.name, "_residual_alone"}, 72'(n_res_alone - ra0), 72'(0));
        chk({t.name, "_align_err"}, 72'(n_aerr - a0), 72'(t.aerr));
        chk({t.name, "_ovf_err"}, 72'(n_oerr - o0), 72'(t.oerr));
        chk({t.name, "_sb_left"}, 72'(sb.size()), 72'(0));
        if (t.lat >= 0) chk({t.name, "_first_latency"}, 72'(sop_cyc - (s + 1)), 72'(t.lat));
        sb.delete();
        $display("scenario %s: words=%0d done=%0d res=%0d aerr=%0d oerr=%0d", t.name,
                 n_words - w0, n_done - d0, n_res - r0, n_aerr - a0, n_oerr - o0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_out_valid"}, 72'(out_valid), 72'(0));
        chk({tag, "_out_data"}, 72'(out_data), 72'(0));
        chk({tag, "_out_sop"}, 72'(out_sop), 72'(0));
        chk({tag, "_burst_done"}, 72'(burst_done), 72'(0));
        chk({tag, "_residual"}, 72'(residual), 72'(0));
        chk({tag, "_align_err"}, 72'(align_err), 72'(0));
        chk({tag, "_ovf_err"}, 72'(ovf_err), 72'(0));
    endtask

    initial begin
        tbl[0] = '{"aligned10", 32'h3FF, 32'h3FF, 32'h3FF, 32'h3FF, 10, 1, 0, 0, 0, 2};
        tbl[1] = '{"skew3", 32'h0FF, 32'h1FE, 32'h3FC, 32'h7F8, 8, 1, 0, 0, 0, -1};
        tbl[2] = '{"skew4_ok", 32'h0FF, 32'h0FF, 32'h0FF, 32'hFF0, 8, 1, 0, 0, 0, -1};
        tbl[3] = '{"skew5_err", 32'h0FF, 32'h0FF, 32'h0FF, 32'h1FE0, 0, 0, 0, 1, 0, -1};
        tbl[4] = '{"skew5_err_again", 32'h0FF, 32'h0FF, 32'h0FF, 32'h1FE0, 0, 0, 0, 1, 0, -1};
        tbl[5] = '{"aligned8", 32'h0FF, 32'h0FF, 32'h0FF, 32'h0FF, 8, 1, 0, 0, 0, 2};
        tbl[6] = '{"residual", 32'h1FF, 32'h1FF, 32'h1FF, 32'h0FF, 8, 1, 1, 0, 0, 2};
        tbl[7] = '{"overflow", 32'hFFFF, 32'hFFFF, 32'hFFFF, 32'h007, 3, 0, 0, 0, 1, 2};
        tbl[8] = '{"aligned6", 32'h03F, 32'h03F, 32'h03F, 32'h03F, 6, 1, 0, 0, 0, 2};
        tbl[9] = '{"after_reset", 32'h3FF, 32'h3FF, 32'h3FF, 32'h3FF, 10, 1, 0, 0, 0, 2};

        base = '0;
        for (int n = 0; n < 4; n++) k_lane[n] = 0;
        rx_valid_hs = '0;
        rx_data_hs_lan0 = '0; rx_data_hs_lan1 = '0; rx_data_hs_lan2 = '0; rx_data_hs_lan3 = '0;
        RST0_N = 1'b1;
        #2 RST0_N = 1'b0;
        #1 chk_all_zero("reset");
        repeat (3) @(negedge SLOWCLK);
        RST0_N = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run_scn(tbl[i], 16'(i * 16'h100 + 16'h10));
        end

        // Reset pulse while word 5 of a burst is on the output.
        base = 16'h0A10;
        push_words(10);
        for (int c = 0; c < 8; c++) step(4'b1111);
        @(posedge SLOWCLK);
        #2 RST0_N = 1'b0;
        #1 chk_all_zero("mid_reset");
        rx_valid_hs = 4'b0000;
        sb.delete();
        last_data = '0;
        step(4'b0000);
        step(4'b0000);
        RST0_N = 1'b1;
        $display("mid-stream reset applied, outputs cleared");

        run_scn(tbl[9], 16'h0B20);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
